// File: rtl/hw_mutex_array.sv
// Bank of independent hardware mutexes: round-robin arbitration, direct owner handoff, message passing.
// Define HW_MUTEX_OWNER_CHECK_EN to accept unlocks only from the owner and flag illegal unlocks on error_o.
module hw_mutex_array #(
   parameter int unsigned  NB_CORES    = 8,
   parameter int unsigned  NB_MUTEX    = 4,
   parameter int unsigned  MUTEX_MSG_W = 32,
   localparam int unsigned ID_W        = $clog2(NB_CORES)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NB_MUTEX-1:0][NB_CORES-1:0]    lock_req_i,
   input  logic [NB_MUTEX-1:0][NB_CORES-1:0]    unlock_req_i,
   input  logic [NB_MUTEX-1:0][MUTEX_MSG_W-1:0] msg_wdata_i,
   output logic [NB_MUTEX-1:0][MUTEX_MSG_W-1:0] msg_rdata_o,
   output logic [NB_MUTEX-1:0][NB_CORES-1:0]    grant_event_o,
   output logic [NB_MUTEX-1:0]                  locked_o,
   output logic [NB_MUTEX-1:0][ID_W-1:0]        owner_o,
   output logic [NB_MUTEX-1:0]                  error_o
);

   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   // First set bit of req strictly after last, wrapping around.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NB_CORES-1:0] req,
                                               input logic [ID_W-1:0]     last);
      logic [ID_W-1:0] pick;
      logic            found;
      int unsigned     idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= NB_CORES; i++) begin
         idx = (32'(last) + i) % NB_CORES;
         if (!found && req[ID_W'(idx)]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   for (genvar m = 0; m < NB_MUTEX; m++) begin : g_mutex
      state_e                  state_q;
      logic [NB_CORES-1:0]     pend_q;
      logic [ID_W-1:0]         rr_last_q;
      logic [ID_W-1:0]         owner_q;
      logic [NB_CORES-1:0]     grant_q;
      logic [MUTEX_MSG_W-1:0]  msg_q;
      logic                    err_q;

      logic [NB_CORES-1:0]     acc;
      logic [NB_CORES-1:0]     req;
      logic [NB_CORES-1:0]     req_ho;
      logic [NB_CORES-1:0]     win_oh;
      logic [ID_W-1:0]         win;
      logic                    unlock_ok;
      logic                    err;

`ifdef HW_MUTEX_OWNER_CHECK_EN
      logic [NB_CORES-1:0]     owner_oh;
`endif

      // Accepted unlock bits, arbitration request vectors and winner.
      always_comb begin
`ifdef HW_MUTEX_OWNER_CHECK_EN
         owner_oh = NB_CORES'(1) << owner_q;
         acc      = unlock_req_i[m] & owner_oh;
         err      = (state_q == ST_FREE) ? (|unlock_req_i[m])
                                         : (|(unlock_req_i[m] & ~owner_oh));
`else
         acc      = unlock_req_i[m];
         err      = 1'b0;
`endif
         unlock_ok = (state_q == ST_LOCKED) && (acc != '0);
         req       = pend_q | lock_req_i[m];
         // A releasing core's same-cycle lock is parked so others win first.
         req_ho    = pend_q | (lock_req_i[m] & ~acc);
         win       = rr_pick(unlock_ok ? req_ho : req, rr_last_q);
         win_oh    = NB_CORES'(1) << win;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q   <= ST_FREE;
            pend_q    <= '0;
            rr_last_q <= ID_W'(NB_CORES - 1);
            owner_q   <= '0;
            grant_q   <= '0;
            msg_q     <= '0;
            err_q     <= 1'b0;
         end else begin
            grant_q <= '0;
            err_q   <= err;
            if (state_q == ST_FREE) begin
               if (req != '0) begin
                  state_q   <= ST_LOCKED;
                  owner_q   <= win;
                  rr_last_q <= win;
                  grant_q   <= win_oh;
                  pend_q    <= req & ~win_oh;
               end
            end else if (unlock_ok) begin
               msg_q <= msg_wdata_i[m];
               if (req_ho != '0) begin
                  owner_q   <= win;
                  rr_last_q <= win;
                  grant_q   <= win_oh;
                  pend_q    <= (req_ho & ~win_oh) | (lock_req_i[m] & acc);
               end else begin
                  state_q <= ST_FREE;
                  pend_q  <= lock_req_i[m] & acc;
               end
            end else begin
               pend_q <= req;
            end
         end
      end

      assign msg_rdata_o[m]   = msg_q;
      assign grant_event_o[m] = grant_q;
      assign locked_o[m]      = (state_q == ST_LOCKED);
      assign owner_o[m]       = owner_q;
      assign error_o[m]       = err_q;
   end

endmodule
